// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-signedness helpers for the
// iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic f_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f_a_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic f_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Launch/result bundle between the ID/EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if;
  import muldiv_pkg::*;

  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, flush_i, funct3_i, rs1_data_i, rs2_data_i, rd_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, rs1_data_i, rs2_data_i, rd_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or
// restoring divide step on a 64-bit {high, low} accumulator.
module muldiv_step (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opb_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_s;
  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;

  // Multiply: add multiplicand when LSB set, shift right. Divide: shift left, trial-subtract.
  always_comb begin
    add_s    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opb_i} : 33'd0);
    rem_sh_s = {acc_i[63:32], acc_i[31]};
    diff_s   = rem_sh_s - {1'b0, opb_i};
    if (is_div_i) begin
      if (diff_s[32]) begin
        acc_o = {rem_sh_s[31:0], acc_i[30:0], 1'b0};
      end else begin
        acc_o = {diff_s[31:0], acc_i[30:0], 1'b1};
      end
    end else begin
      acc_o = {add_s, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, sign handling
// and registered result/rd outputs around the muldiv_step datapath.
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  ex_muldiv_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic        div_zero_s, div_ovf_s;
  logic [63:0] step_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;

  muldiv_step u_step (
    .is_div_i (f_is_div(op_q)),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (step_s)
  );

  // Operand magnitudes, special-case detection and final sign correction.
  always_comb begin
    a_neg_s    = f_a_signed(bus.funct3_i) & bus.rs1_data_i[31];
    b_neg_s    = f_b_signed(bus.funct3_i) & bus.rs2_data_i[31];
    a_mag_s    = a_neg_s ? (32'd0 - bus.rs1_data_i) : bus.rs1_data_i;
    b_mag_s    = b_neg_s ? (32'd0 - bus.rs2_data_i) : bus.rs2_data_i;
    div_zero_s = f_is_div(bus.funct3_i) & (bus.rs2_data_i == 32'd0);
    div_ovf_s  = f_is_div(bus.funct3_i) & ~bus.funct3_i[0] &
                 (bus.rs1_data_i == 32'h8000_0000) & (bus.rs2_data_i == 32'hFFFF_FFFF);
    prod_s     = neg_q ? (64'd0 - step_s) : step_s;
    quo_s      = neg_q ? (32'd0 - step_s[31:0]) : step_s[31:0];
    rem_s      = neg_q ? (32'd0 - step_s[63:32]) : step_s[63:32];
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d  = bus.funct3_i;
          rd_d  = bus.rd_i;
          cnt_d = 6'd0;
          if (f_is_div(bus.funct3_i)) begin
            neg_d = bus.funct3_i[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
            acc_d = {32'd0, a_mag_s};
            opb_d = b_mag_s;
          end else begin
            neg_d = a_neg_s ^ b_neg_s;
            acc_d = {32'd0, b_mag_s};
            opb_d = a_mag_s;
          end
          if (div_zero_s) begin
            result_d = bus.funct3_i[1] ? bus.rs1_data_i : 32'hFFFF_FFFF;
            rd_out_d = bus.rd_i;
            state_d  = ST_DONE;
          end else if (div_ovf_s) begin
            result_d = bus.funct3_i[1] ? 32'd0 : 32'h8000_0000;
            rd_out_d = bus.rd_i;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = ST_DONE;
            rd_out_d = rd_q;
            case (op_q)
              F3_MUL:                       result_d = prod_s[31:0];
              F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_s[63:32];
              F3_DIV, F3_DIVU:              result_d = quo_s;
              F3_REM, F3_REMU:              result_d = rem_s;
              default:                      result_d = 32'd0;
            endcase
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases, special cases,
// flush, reset mid-operation, ignored starts and random ops against a reference model.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  ex_muldiv_unit_if mbus ();

  ex_muldiv_unit dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (mbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'sd0;
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      3'b111: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 1;
    if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Launch one op, optionally poke a spurious start at cycle 'poke', and score the done pulse.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat, input int poke);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   busy_bad;
    @(negedge clk);
    mbus.start_i    = 1'b1;
    mbus.funct3_i   = f3;
    mbus.rs1_data_i = a;
    mbus.rs2_data_i = b;
    mbus.rd_i       = rd;
    sb_q.push_back('{exp_res, rd, exp_lat});
    cyc = 0; seen = 1'b0; busy_bad = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mbus.busy_o !== 1'b1) busy_bad = 1'b1;
      if (mbus.done_o === 1'b1) begin
        seen = 1'b1;
        e = sb_q.pop_front();
        checks++;
        if (mbus.result_o !== e.res) begin
          errors++; $display("FAIL %s result: got %h expected %h", name, mbus.result_o, e.res);
        end
        checks++;
        if (mbus.rd_o !== e.rd) begin
          errors++; $display("FAIL %s rd: got %0d expected %0d", name, mbus.rd_o, e.rd);
        end
        checks++;
        if (cyc != e.lat) begin
          errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
        end
        last_res = e.res;
      end
      mbus.start_i = (cyc == poke);
      if (cyc == poke) begin
        mbus.funct3_i   = 3'b101;
        mbus.rs1_data_i = 32'd99;
        mbus.rs2_data_i = 32'd0;
        mbus.rd_i       = 5'd31;
      end
    end
    mbus.start_i = 1'b0;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: got no done_o expected done in cycle %0d", name, exp_lat);
      void'(sb_q.pop_front());
    end
    checks++;
    if (busy_bad) begin
      errors++; $display("FAIL %s busy: got busy_o low expected high until done", name);
    end
    @(negedge clk);
    checks++;
    if (mbus.busy_o !== 1'b0 || mbus.done_o !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got busy=%b done=%b expected 0 0", name, mbus.busy_o, mbus.done_o);
    end
    checks++;
    if (mbus.result_o !== last_res) begin
      errors++; $display("FAIL %s hold: got %h expected %h", name, mbus.result_o, last_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mbus.start_i = 1'b0; mbus.flush_i = 1'b0; mbus.funct3_i = 3'd0;
    mbus.rs1_data_i = 32'd0; mbus.rs2_data_i = 32'd0; mbus.rd_i = 5'd0;
    last_res = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mbus.busy_o, mbus.done_o, mbus.result_o, mbus.rd_o} !== 39'd0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b res=%h rd=%0d expected all 0",
                         mbus.busy_o, mbus.done_o, mbus.result_o, mbus.rd_o);
    end
  endtask

  task automatic test_mul();
    do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, -1);
    do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, -1);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, -1);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 33, -1);
  endtask

  task automatic test_div();
    do_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFD, 33, -1);
    do_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33, -1);
    do_op("divu", 3'b101, 32'd100,       32'd7, 5'd11, 32'd14,        33, -1);
    do_op("remu", 3'b111, 32'd100,       32'd7, 5'd12, 32'd2,         33, -1);
  endtask

  task automatic test_special();
    do_op("divu_by0", 3'b101, 32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1, -1);
    do_op("remu_by0", 3'b111, 32'h1234,      32'd0,         5'd14, 32'h0000_1234, 1, -1);
    do_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, -1);
    do_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1, -1);
  endtask

  task automatic test_start_while_busy();
    do_op("ignored_start", 3'b000, 32'd3, 32'd5, 5'd17, 32'd15, 33, 5);
  endtask

  task automatic test_flush();
    bit done_seen;
    @(negedge clk);
    mbus.start_i = 1'b1; mbus.funct3_i = 3'b100;
    mbus.rs1_data_i = 32'd1000; mbus.rs2_data_i = 32'd3; mbus.rd_i = 5'd20;
    @(negedge clk);
    mbus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    mbus.flush_i = 1'b1;
    @(negedge clk);
    mbus.flush_i = 1'b0;
    checks++;
    if (mbus.busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b expected 0", mbus.busy_o);
    end
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mbus.done_o !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL flush_done: got done_o pulse expected none");
    end
    checks++;
    if (mbus.result_o !== last_res) begin
      errors++; $display("FAIL flush_hold: got %h expected %h", mbus.result_o, last_res);
    end
    mbus.start_i = 1'b1; mbus.flush_i = 1'b1; mbus.funct3_i = 3'b101;
    mbus.rs1_data_i = 32'd5; mbus.rs2_data_i = 32'd0; mbus.rd_i = 5'd21;
    @(negedge clk);
    mbus.start_i = 1'b0; mbus.flush_i = 1'b0;
    checks++;
    if (mbus.busy_o !== 1'b0 || mbus.done_o !== 1'b0) begin
      errors++; $display("FAIL flush_start: got busy=%b done=%b expected 0 0", mbus.busy_o, mbus.done_o);
    end
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    @(negedge clk);
    mbus.start_i = 1'b1; mbus.funct3_i = 3'b000;
    mbus.rs1_data_i = 32'd11; mbus.rs2_data_i = 32'd13; mbus.rd_i = 5'd22;
    @(negedge clk);
    mbus.start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mbus.busy_o, mbus.done_o, mbus.result_o, mbus.rd_o} !== 39'd0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b res=%h rd=%0d expected all 0",
                         mbus.busy_o, mbus.done_o, mbus.result_o, mbus.rd_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mbus.done_o !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL reset_mid_done: got done_o pulse expected none");
    end
    do_op("mul_after_reset", 3'b000, 32'd3, 32'd4, 5'd23, 32'd12, 33, -1);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
      do_op("random", f3, a, b, 5'(i + 1), ref_op(f3, a, b), ref_lat(f3, a, b), -1);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_while_busy();
    test_flush();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
